// File: rtl/instruction_fetch_unit.sv
// Decoupled instruction fetch: in-order requests to a variable-latency memory, a DEPTH-entry
// buffer toward decode, and a redirect that flushes the buffer and drops stale responses.
module instruction_fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic              o_imem_req_valid,
    input  logic              i_imem_req_ready,
    output logic [ADDR_W-1:0] o_imem_req_addr,
    input  logic              i_imem_rsp_valid,
    input  logic [DATA_W-1:0] i_imem_rsp_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_instruction,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_increment
);

    localparam int unsigned       STEP      = DATA_W / 8;
    localparam int unsigned       PTR_W     = $clog2(DEPTH);
    localparam int unsigned       CNT_W     = PTR_W + 1;
    localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] PC_ALIGN  = ~(ADDR_W'(STEP - 1));
    localparam logic [CNT_W:0]    DEPTH_EXT = (CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  alloc_q, alloc_d;
    logic [PTR_W-1:0]  fill_q, fill_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    // Allocated entries still waiting for their response.
    logic [CNT_W-1:0]  pend_q, pend_d;

    logic [ADDR_W-1:0] pc_q    [DEPTH];
    logic [DATA_W-1:0] instr_q [DEPTH];
    logic [DEPTH-1:0]  filled_q;

    logic [CNT_W:0] credit_used;
    logic           has_credit;
    logic           req_fire;
    logic           deq_fire;
    logic           rsp_drop;
    logic           rsp_fill;

    assign credit_used = {1'b0, count_q} + {1'b0, drop_cnt_q};
    assign has_credit  = credit_used < DEPTH_EXT;

    assign o_imem_req_valid = i_reset && !i_redirect && has_credit;
    assign o_imem_req_addr  = fetch_pc_q;
    assign o_valid          = filled_q[head_q] && !i_redirect;
    assign o_instruction    = instr_q[head_q];
    assign o_pc             = pc_q[head_q];
    assign o_pc_increment   = pc_q[head_q] + PC_STEP;

    assign req_fire = o_imem_req_valid && i_imem_req_ready;
    assign deq_fire = o_valid && i_ready;
    assign rsp_drop = i_imem_rsp_valid && (drop_cnt_q != '0);
    assign rsp_fill = i_imem_rsp_valid && (drop_cnt_q == '0) && !i_redirect;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        alloc_d    = alloc_q;
        fill_d     = fill_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;
        pend_d     = pend_q;
        if (i_redirect) begin
            // Every response still owed, minus one arriving now, becomes stale.
            head_d     = alloc_q;
            fill_d     = alloc_q;
            count_d    = '0;
            pend_d     = '0;
            drop_cnt_d = drop_cnt_q + pend_q - CNT_W'(i_imem_rsp_valid);
            fetch_pc_d = i_redirect_pc & PC_ALIGN;
        end else begin
            if (req_fire) begin
                alloc_d    = alloc_q + PTR_W'(1);
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (deq_fire) begin
                head_d = head_q + PTR_W'(1);
            end
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end
            if (rsp_fill) begin
                fill_d = fill_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(req_fire) - CNT_W'(deq_fire);
            pend_d  = pend_q + CNT_W'(req_fire) - CNT_W'(rsp_fill);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            alloc_q    <= '0;
            fill_q     <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
            pend_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            alloc_q    <= alloc_d;
            fill_q     <= fill_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
            pend_q     <= pend_d;
        end
    end

    // Alloc, fill and head always address distinct slots when they fire together.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            filled_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= RESET_PC;
                instr_q[i] <= '0;
            end
        end else if (i_redirect) begin
            filled_q <= '0;
        end else begin
            if (req_fire) begin
                pc_q[alloc_q]     <= fetch_pc_q;
                filled_q[alloc_q] <= 1'b0;
            end
            if (rsp_fill) begin
                instr_q[fill_q]  <= i_imem_rsp_data;
                filled_q[fill_q] <= 1'b1;
            end
            if (deq_fire) begin
                filled_q[head_q] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit: the bench plays the instruction memory and
// checks every cycle against a queue-based model of issued, in-flight and stale fetches.
module tb_instruction_fetch_unit;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready = 1'b0;
    logic [31:0] o_imem_req_addr;
    logic        i_imem_rsp_valid = 1'b0;
    logic [31:0] i_imem_rsp_data = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_instruction;
    logic [31:0] o_pc;
    logic [31:0] o_pc_increment;

    instruction_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .i_clk            (clk),
        .i_reset          (rst_n),
        .i_redirect       (i_redirect),
        .i_redirect_pc    (i_redirect_pc),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (i_imem_req_ready),
        .o_imem_req_addr  (o_imem_req_addr),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_data  (i_imem_rsp_data),
        .o_valid          (o_valid),
        .i_ready          (i_ready),
        .o_instruction    (o_instruction),
        .o_pc             (o_pc),
        .o_pc_increment   (o_pc_increment)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          due;
        bit          stale;
    } mem_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        bit          resp;
    } exp_t;

    mem_t        mem_q[$];
    exp_t        out_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] model_pc = RESET_PC;

    int unsigned lat_lo = 1, lat_hi = 1;
    int unsigned req_rdy_pct = 100, dec_rdy_pct = 100, redir_pct = 0;
    bit          redir_force = 1'b0;
    bit          redir_on_rsp = 1'b0;
    bit          last_redir = 1'b0;
    logic [31:0] redir_target = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic step();
        bit   rsp_drive, redir, exp_req_valid, exp_valid;
        int   stale_n;
        mem_t m;
        exp_t e;

        rsp_drive = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        i_imem_rsp_valid = rsp_drive;
        i_imem_rsp_data  = rsp_drive ? mem_q[0].data : $urandom;
        if (redir_force) redir = !redir_on_rsp || rsp_drive;
        else             redir = $urandom_range(99) < redir_pct;
        i_redirect       = redir;
        i_redirect_pc    = (redir && redir_force) ? redir_target : $urandom;
        i_imem_req_ready = $urandom_range(99) < req_rdy_pct;
        i_ready          = $urandom_range(99) < dec_rdy_pct;
        last_redir       = redir;
        #1;

        stale_n = 0;
        foreach (mem_q[k]) if (mem_q[k].stale) stale_n++;
        exp_req_valid = !redir && (out_q.size() + stale_n < DEPTH);
        exp_valid     = !redir && (out_q.size() > 0) && out_q[0].resp;

        check("req_valid", 32'(o_imem_req_valid), 32'(exp_req_valid));
        check("valid", 32'(o_valid), 32'(exp_valid));
        if (exp_req_valid) check("req_addr", o_imem_req_addr, model_pc);
        if (exp_valid) begin
            check("pc", o_pc, out_q[0].pc);
            check("instruction", o_instruction, out_q[0].data);
            check("pc_increment", o_pc_increment, out_q[0].pc + 32'd4);
        end

        if (rsp_drive) begin
            m = mem_q.pop_front();
            if (!m.stale && !redir) begin
                for (int k = 0; k < out_q.size(); k++) begin
                    if (!out_q[k].resp) begin
                        out_q[k].resp = 1'b1;
                        break;
                    end
                end
            end
        end
        if (redir) begin
            out_q.delete();
            foreach (mem_q[k]) mem_q[k].stale = 1'b1;
            model_pc = i_redirect_pc & ~32'h3;
        end else begin
            if (exp_valid && i_ready) void'(out_q.pop_front());
            if (exp_req_valid && i_imem_req_ready) begin
                m.data  = $urandom;
                m.due   = cyc + int'($urandom_range(lat_hi, lat_lo));
                m.stale = 1'b0;
                mem_q.push_back(m);
                e.pc   = model_pc;
                e.data = m.data;
                e.resp = 1'b0;
                out_q.push_back(e);
                model_pc = model_pc + 32'd4;
            end
        end

        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic quiet_inputs();
        i_redirect       = 1'b0;
        i_imem_rsp_valid = 1'b0;
        i_imem_req_ready = 1'b0;
        i_ready          = 1'b0;
    endtask

    initial begin
        // Reset values while held in reset.
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(o_valid), 32'h0);
        check("rst_req_valid", 32'(o_imem_req_valid), 32'h0);
        check("rst_req_addr", o_imem_req_addr, RESET_PC);
        check("rst_pc", o_pc, RESET_PC);
        check("rst_pc_increment", o_pc_increment, RESET_PC + 32'd4);
        check("rst_instruction", o_instruction, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming with a 1-cycle memory and decode always ready.
        run(20);

        // Decode stall fills the buffer, then drains.
        dec_rdy_pct = 0;
        run(10);
        check("stall_full_req_valid", 32'(o_imem_req_valid), 32'h0);
        dec_rdy_pct = 100;
        run(10);

        // Redirect with three responses in flight at latency 5.
        lat_lo = 5; lat_hi = 5;
        run(3);
        redir_force = 1'b1; redir_on_rsp = 1'b0; redir_target = 32'h100;
        step();
        redir_force = 1'b0;
        check("redirect_stale_count", 32'(mem_q.size()), 32'd3);
        run(20);

        // Redirect coinciding with a response and a ready decode.
        lat_lo = 2; lat_hi = 2;
        run(4);
        redir_force = 1'b1; redir_on_rsp = 1'b1; redir_target = 32'h200;
        for (int i = 0; i < 10 && !last_redir; i++) step();
        redir_force = 1'b0;
        check("redirect_on_rsp_fired", 32'(last_redir), 32'h1);
        run(15);

        // Unaligned redirect near the top of the address space wraps the PC.
        lat_lo = 1; lat_hi = 1;
        redir_force = 1'b1; redir_on_rsp = 1'b0; redir_target = 32'hFFFF_FFFA;
        step();
        redir_force = 1'b0;
        run(10);

        // Request back-pressure for three cycles.
        req_rdy_pct = 0;
        run(3);
        req_rdy_pct = 100;
        run(10);

        // Random mix of latency, back-pressure, stalls and redirects.
        lat_lo = 1; lat_hi = 4;
        req_rdy_pct = 75; dec_rdy_pct = 70; redir_pct = 5;
        run(300);

        // Asynchronous reset in the middle of a cycle.
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(o_valid), 32'h0);
        check("async_rst_req_valid", 32'(o_imem_req_valid), 32'h0);
        check("async_rst_pc", o_pc, RESET_PC);
        mem_q.delete();
        out_q.delete();
        model_pc = RESET_PC;
        quiet_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(60);

        lat_lo = 1; lat_hi = 1;
        req_rdy_pct = 100; dec_rdy_pct = 100; redir_pct = 0;
        run(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
